// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampling UART receiver, LSB first, no parity
`timescale 1ns/1ps
module uart_receiver #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx,
  input  logic             s_tick,
  output logic [DBITS-1:0] rx_dout,
  output logic             rx_done_tick,
  output logic             frame_err
);

  // s must reach both 15 (data bit) and SB_TICK-1 (stop bit)
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = ($clog2(DBITS) > 1) ? $clog2(DBITS) : 1;

  localparam logic [SW-1:0] S_MID   = SW'(7);
  localparam logic [SW-1:0] S_BIT   = SW'(15);
  localparam logic [SW-1:0] S_STOP  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state;
  logic [SW-1:0]    s;
  logic [NW-1:0]    n;
  logic [DBITS-1:0] b;
  logic             rx_meta;
  logic             rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          // Entry is tick-independent; a coincident tick is deliberately not counted
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rx_s, b[DBITS-1:1]};
              if (n == N_LAST) state <= STOP;
              else             n     <= n + NW'(1);
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              state        <= IDLE;
              rx_dout      <= b;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
